hdmi_refresh_ctrl: RTL and testbench

Avalon-MM slave controller for the HDMI frame-refresh strobe. Synchronizes the raw refresh input, detects rising edges, counts frames, raises a divisible refresh interrupt, and schedules front/back frame-buffer swaps so they commit only on a refresh edge. It sits between the HDMI timing generator and the Nios CPU and drives the buffer-select line of the frame-buffer reader.

---
 rtl/hdmi_refresh_ctrl_if.sv | 10 +
 rtl/hdmi_refresh_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hdmi_refresh_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_refresh_ctrl_if.sv
// Avalon-MM register bus between the Nios CPU and the HDMI refresh controller.
interface hdmi_refresh_ctrl_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input  address, write, writedata, output readdata);
    modport master (output address, write, writedata, input  readdata);
endinterface

// File: rtl/hdmi_refresh_ctrl.sv
// HDMI frame-refresh controller: synchronized refresh edges, frame counter, divided irq and
// edge-committed buffer swaps. Optional stall watchdog compiled in with REFRESH_WATCHDOG_EN.
module hdmi_refresh_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FCNT_W      = 32,
    parameter int unsigned WDOG_CYCLES = 2000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    hdmi_refresh_ctrl_if.slave        bus,
    input  logic                      in_port,
    output logic                      irq,
    output logic                      buf_sel,
    output logic                      swap_pending
);

    localparam int unsigned DIV_W = 8;
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_FCNT    = 3'd3;
    localparam logic [2:0] ADDR_SWAP    = 3'd4;
    localparam logic [2:0] ADDR_DIVIDER = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, edge_q, sync_c;
    logic                   irq_en_q, irq_en_d;
    logic                   flag_q, flag_d, flag_set_c;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic [DIV_W-1:0]       div_q, div_d, div_cnt_q, div_cnt_d;
    logic                   buf_q, buf_d, pend_q, pend_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rd_q, rd_d;
    logic                   stall_q, stall_d;
    logic                   wr_ctrl_c, wr_edge_c, wr_fcnt_c, wr_swap_c, wr_div_c;
    logic                   unused_wd;

    assign sync_c    = sync_q[SYNC_STAGES-1];
    assign wr_ctrl_c = bus.write && (bus.address == ADDR_CONTROL);
    assign wr_edge_c = bus.write && (bus.address == ADDR_EDGE);
    assign wr_fcnt_c = bus.write && (bus.address == ADDR_FCNT);
    assign wr_swap_c = bus.write && (bus.address == ADDR_SWAP);
    assign wr_div_c  = bus.write && (bus.address == ADDR_DIVIDER);
    assign unused_wd = ^bus.writedata[31:DIV_W];

    // Metastability chain plus registered rising-edge pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync_c;
            edge_q <= sync_c & ~prev_q;
        end
    end

`ifdef REFRESH_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counts cycles since the last edge, saturating at the limit
    always_comb begin
        wdog_d  = wdog_q;
        stall_d = stall_q;
        if (edge_q) begin
            wdog_d  = '0;
            stall_d = 1'b0;
        end else if (wdog_q != WDOG_W'(WDOG_CYCLES)) begin
            wdog_d  = wdog_q + WDOG_W'(1);
            stall_d = (wdog_d == WDOG_W'(WDOG_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            stall_q <= stall_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign stall_q     = 1'b0;
    assign stall_d     = 1'b0;
`endif

    always_comb begin
        irq_en_d   = irq_en_q;
        fcnt_d     = fcnt_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        flag_set_c = 1'b0;
        flag_d     = flag_q;
        buf_d      = buf_q;
        pend_d     = pend_q;
        rd_d       = '0;

        if (wr_ctrl_c) irq_en_d = bus.writedata[0];

        if (edge_q)    fcnt_d = fcnt_q + FCNT_W'(1);
        if (wr_fcnt_c) fcnt_d = '0;

        // A divider write restarts the division and swallows a coincident edge
        if (wr_div_c) begin
            div_d     = bus.writedata[DIV_W-1:0];
            div_cnt_d = '0;
        end else if (edge_q) begin
            if (div_cnt_q == div_q) begin
                flag_set_c = 1'b1;
                div_cnt_d  = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (wr_edge_c && bus.writedata[0]) flag_d = 1'b0;
        if (flag_set_c)                    flag_d = 1'b1;

        // A swap request landing on an edge waits for the following edge
        if (wr_swap_c && bus.writedata[0]) begin
            pend_d = 1'b1;
        end else if (edge_q && pend_q) begin
            buf_d  = ~buf_q;
            pend_d = 1'b0;
        end

        irq_d = irq_en_d & (flag_d | stall_d);

        case (bus.address)
            ADDR_STATUS:  rd_d = 32'({stall_q, flag_q, buf_q, pend_q, sync_c});
            ADDR_CONTROL: rd_d = 32'(irq_en_q);
            ADDR_EDGE:    rd_d = 32'(flag_q);
            ADDR_FCNT:    rd_d = 32'(fcnt_q);
            ADDR_SWAP:    rd_d = 32'(pend_q);
            ADDR_DIVIDER: rd_d = 32'(div_q);
            default:      rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q  <= 1'b0;
            fcnt_q    <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            flag_q    <= 1'b0;
            buf_q     <= 1'b0;
            pend_q    <= 1'b0;
            irq_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            irq_en_q  <= irq_en_d;
            fcnt_q    <= fcnt_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            flag_q    <= flag_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.readdata = rd_q;
    assign irq          = irq_q;
    assign buf_sel      = buf_q;
    assign swap_pending = pend_q;

endmodule

// File: tb/tb_hdmi_refresh_ctrl.sv
// Scoreboard bench for hdmi_refresh_ctrl: event-level reference model feeds expected reads/pins.
module tb_hdmi_refresh_ctrl;
    localparam int unsigned FCNT_W = 4;
    localparam int unsigned WDOG   = 100;
`ifdef REFRESH_WATCHDOG_EN
    localparam bit WD_BUILD = 1'b1;
`else
    localparam bit WD_BUILD = 1'b0;
`endif
    localparam logic [31:0] ST_MASK  = WD_BUILD ? 32'hFFFF_FFEF : 32'hFFFF_FFFF;
    localparam logic [31:0] PIN_MASK = WD_BUILD ? 32'h0000_0003 : 32'h0000_0007;

    logic clk = 1'b0, reset_n = 1'b0, in_port = 1'b0;
    logic irq, buf_sel, swap_pending;

    hdmi_refresh_ctrl_if bus_if();

    hdmi_refresh_ctrl #(.SYNC_STAGES(2), .FCNT_W(FCNT_W), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if.slave), .in_port(in_port),
        .irq(irq), .buf_sel(buf_sel), .swap_pending(swap_pending));

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] exp; logic [31:0] mask; } exp_t;
    exp_t rd_q[$];
    exp_t pin_q[$];
    int n_cmp = 0, n_err = 0;
    logic rd_req = 1'b0, rd_vld = 1'b0, pin_req = 1'b0, pin_vld = 1'b0;

    // Reference model: state of the block expressed per refresh event
    int m_cnt, m_div, m_n;
    bit m_flag, m_irq_en, m_pend, m_buf;

    task automatic model_reset();
        m_cnt = 0; m_div = 0; m_n = 0;
        m_flag = 0; m_irq_en = 0; m_pend = 0; m_buf = 0;
    endtask

    task automatic model_edge();
        m_cnt = (m_cnt + 1) % (1 << FCNT_W);
        m_n++;
        if (m_n % (m_div + 1) == 0) m_flag = 1;
        if (m_pend) begin m_buf = !m_buf; m_pend = 0; end
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd1: m_irq_en = d[0];
            3'd2: if (d[0]) m_flag = 0;
            3'd3: m_cnt = 0;
            3'd4: if (d[0]) m_pend = 1;
            3'd5: begin m_div = int'(d[7:0]); m_n = 0; end
            default: ;
        endcase
    endtask

    task automatic model_coll(input logic [2:0] a, input logic [31:0] d);
        bit f;
        case (a)
            3'd2: begin model_write(a, d); model_edge(); end
            3'd3: begin model_edge(); m_cnt = 0; end
            3'd4: if (d[0]) begin m_pend = 0; model_edge(); m_pend = 1; end
                  else model_edge();
            3'd5: begin f = m_flag; model_edge(); m_flag = f; model_write(a, d); end
            default: begin model_edge(); model_write(a, d); end
        endcase
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0: return {27'b0, 1'b0, m_flag, m_buf, m_pend, 1'b0};
            3'd1: return 32'(m_irq_en);
            3'd2: return 32'(m_flag);
            3'd3: return 32'(m_cnt);
            3'd4: return 32'(m_pend);
            3'd5: return 32'(m_div);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_vld  <= rd_req;
        pin_vld <= pin_req;
    end

    // Monitor: pops an expectation whenever a read result or pin sample is presented
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: read result with no expectation");
            end else begin
                e = rd_q.pop_front();
                act = bus_if.readdata;
                if (((act ^ e.exp) & e.mask) != 0) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act & e.mask, e.exp & e.mask);
                end
            end
        end
        if (pin_vld) begin
            n_cmp++;
            if (pin_q.size() == 0) begin
                n_err++;
                $display("FAIL pin_underflow: pin sample with no expectation");
            end else begin
                e = pin_q.pop_front();
                act = {29'b0, irq, buf_sel, swap_pending};
                if (((act ^ e.exp) & e.mask) != 0) begin
                    n_err++;
                    $display("FAIL %s: got {irq,buf,pend}=%03b expected %03b", e.name,
                             3'(act & e.mask), 3'(e.exp & e.mask));
                end
            end
        end
    end

    task automatic read_chk(input logic [2:0] a, input string name);
        exp_t e;
        e.name = name; e.exp = model_rd(a);
        e.mask = (a == 3'd0) ? ST_MASK : 32'hFFFF_FFFF;
        rd_q.push_back(e);
        bus_if.address = a; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic pin_chk(input string name);
        exp_t e;
        e.name = name; e.exp = {29'b0, m_flag & m_irq_en, m_buf, m_pend}; e.mask = PIN_MASK;
        pin_q.push_back(e);
        pin_req = 1'b1;
        @(negedge clk);
        pin_req = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.address = a; bus_if.writedata = d; bus_if.write = 1'b1;
        @(negedge clk);
        bus_if.write = 1'b0;
        model_write(a, d);
    endtask

    task automatic pulse();
        in_port = 1'b1; repeat (4) @(negedge clk);
        in_port = 1'b0; repeat (4) @(negedge clk);
        model_edge();
    endtask

    // Write lands in the cycle the edge pulse is high (in_port rise + 3 clocks)
    task automatic pulse_coll(input logic [2:0] a, input logic [31:0] d);
        in_port = 1'b1; repeat (3) @(negedge clk);
        bus_if.address = a; bus_if.writedata = d; bus_if.write = 1'b1;
        @(negedge clk);
        bus_if.write = 1'b0;
        repeat (3) @(negedge clk);
        in_port = 1'b0; repeat (4) @(negedge clk);
        model_coll(a, d);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; repeat (2) @(negedge clk);
        reset_n = 1'b1; model_reset();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk_data(input logic [2:0] a);
        logic [31:0] r;
        r = $urandom();
        if (a == 3'd5) r[7:0] = 8'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        logic [2:0] aa;
        logic [2:0] misc [4];
        misc[0] = 3'd0; misc[1] = 3'd3; misc[2] = 3'd6; misc[3] = 3'd7;
        bus_if.address = 3'd0; bus_if.write = 1'b0; bus_if.writedata = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();
        for (int a = 0; a < 8; a++) read_chk(3'(a), $sformatf("reset_rd%0d", a));
        pin_chk("reset_pins");

        bus_write(3'd1, 32'h1);
        bus_write(3'd5, 32'h0);
        repeat (3) pulse();
        read_chk(3'd3, "fcnt_after3");
        read_chk(3'd2, "flag_after3");
        pin_chk("irq_after3");
        bus_write(3'd2, 32'h1);
        pin_chk("irq_cleared");

        bus_write(3'd3, 32'h0);
        bus_write(3'd5, 32'h2);
        for (int i = 1; i <= 6; i++) begin
            pulse();
            read_chk(3'd2, $sformatf("div2_flag_p%0d", i));
            if (i == 3) bus_write(3'd2, 32'h1);
        end
        read_chk(3'd3, "div2_fcnt");

        bus_write(3'd5, 32'h0);
        bus_write(3'd4, 32'h1);
        pin_chk("swap_req");
        bus_write(3'd4, 32'h1);
        pulse();
        pin_chk("swap_commit");
        pulse_coll(3'd4, 32'h1);
        pin_chk("swap_deferred");
        read_chk(3'd0, "status_deferred");
        pulse();
        pin_chk("swap_commit2");

        bus_write(3'd3, 32'h0);
        repeat (15) pulse();
        read_chk(3'd3, "fcnt_15");
        pulse();
        read_chk(3'd3, "fcnt_wrap");
        repeat (2) pulse();
        pulse_coll(3'd3, 32'h0);
        read_chk(3'd3, "fcnt_coll");
        pulse_coll(3'd2, 32'h1);
        read_chk(3'd2, "edge_clr_coll");
        bus_write(3'd2, 32'h1);
        pulse_coll(3'd5, 32'h1);
        read_chk(3'd2, "div_coll_flag");
        pulse(); pulse();
        read_chk(3'd2, "div_coll_after");

        bus_write(3'd4, 32'h1);
        in_port = 1'b1; @(negedge clk);
        reset_n = 1'b0; repeat (2) @(negedge clk);
        reset_n = 1'b1; model_reset();
        repeat (5) @(negedge clk);
        in_port = 1'b0; repeat (4) @(negedge clk);
        model_edge();
        read_chk(3'd3, "rst_high_fcnt");
        read_chk(3'd0, "rst_high_status");
        pin_chk("rst_high_pins");

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pulse();
                4: bus_write(3'd1, mk_data(3'd1));
                5: bus_write(3'd2, mk_data(3'd2));
                6: bus_write(3'd4, mk_data(3'd4));
                7: bus_write(3'd5, mk_data(3'd5));
                8: begin aa = 3'($urandom_range(1, 5)); pulse_coll(aa, mk_data(aa)); end
                default: bus_write(misc[$urandom_range(0, 3)], $urandom());
            endcase
            aa = 3'($urandom_range(0, 7));
            read_chk(aa, $sformatf("rand%0d_rd%0d", it, aa));
            pin_chk($sformatf("rand%0d_pins", it));
        end

`ifdef REFRESH_WATCHDOG_EN
        begin
            exp_t e;
            do_reset();
            bus_write(3'd1, 32'h1);
            repeat (110) @(negedge clk);
            e.name = "wdog_stall"; e.exp = 32'h10; e.mask = 32'h10; rd_q.push_back(e);
            bus_if.address = 3'd0; rd_req = 1'b1; @(negedge clk); rd_req = 1'b0;
            e.name = "wdog_irq"; e.exp = 32'h4; e.mask = 32'h4; pin_q.push_back(e);
            pin_req = 1'b1; @(negedge clk); pin_req = 1'b0;
            pulse();
            e.name = "wdog_cleared"; e.exp = 32'h0; e.mask = 32'h10; rd_q.push_back(e);
            bus_if.address = 3'd0; rd_req = 1'b1; @(negedge clk); rd_req = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_q.size() != 0 || pin_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d reads and %0d pin samples left unchecked, expected 0",
                     rd_q.size(), pin_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule
